seu_error_arbiter: RTL
======================

Name: seu_error_arbiter

Overview:
- Collects TMR voter error flags from NREQ independent triplicated domains (pipeline stages, registers) and feeds them into one shared SEU event counter.
- A round-robin arbiter grants one event per cycle into the counter.
- A read FSM drains pending events, snapshots the count and, optionally, clears it without losing events that arrive meanwhile.
- Sits between the voter error outputs and the slow-control readout.

Parameters:
- NREQ, 4, number of error sources (2..32)
- CNTW, 8, SEU counter width in bits
- DRAIN_MAX, 8, maximum DRAIN cycles before a forced snapshot (1..255)

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- tmrErr  input  NREQ  per-source voter mismatch flag (level)
- rdReq  input  1  readout request, single-cycle pulse
- clrOnRead  input  1  sampled with rdReq; 1 = clear counter on acknowledge
- rdValid  output  1  snapshot valid
- rdAck  input  1  snapshot consumed
- rdData  output  CNTW  snapshot of counter
- rdOverflow  output  1  counter was saturated at snapshot
- rdDropped  output  1  at least one event was lost before snapshot
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset (async, rst=1), all cleared to 0:
  - outputs rdValid, rdData, rdOverflow, rdDropped, busy
  - internal count, sat, dropped, pending[], the tmrErr delay register, and the arbiter pointer ptr
  - FSM state = IDLE
  - rst mid-readout aborts the read; rdValid drops immediately.
- Event detect: ev[i] = tmrErr[i] & ~tmrErrD[i] (rising edge, registered). Level high for many cycles counts once.
- Pending bits:
  - ev[i] sets pending[i].
  - A grant clears pending[i], except when ev[i] is also asserted that cycle: set wins and pending stays 1.
  - ev[i] while pending[i]=1 and i not granted: sticky dropped=1.
- Arbiter, one grant per cycle when any pending:
  - grant g = first pending index at or after ptr, wrapping modulo NREQ.
  - Next cycle ptr = (g+1) mod NREQ.
  - Granted cycle: count increments.
  - Saturates at 2^CNTW-1; sat=1 once an increment is attempted at max.
- FSM IDLE -> DRAIN -> HOLD -> IDLE.
  - IDLE:
    - rdReq=1: latch clrOnRead into clrPend; go to DRAIN; load drain counter with 0.
    - rdReq in DRAIN or HOLD is ignored.
  - DRAIN:
    - Arbiter keeps running.
    - Exit when pending==0 at cycle start, or drain counter == DRAIN_MAX-1.
    - On exit, register rdData = count after this cycle's grant, rdOverflow = sat, rdDropped = dropped.
    - Set rdValid=1 and go to HOLD.
  - HOLD:
    - rdData, rdOverflow and rdDropped stay stable; the counter stays live.
    - rdAck=1: rdValid=0, go to IDLE.
    - If clrPend=1 on that same rdAck cycle: count <= (count - rdData) + grant, preserving events accumulated during HOLD. If sat=1: count <= grant.
    - sat and dropped are cleared on that cycle; dropped is re-set if a drop happens the same cycle.
    - rdAck outside HOLD is ignored.
- busy = (state != IDLE).
- Latency with nothing pending: rdReq at cycle 0 gives state DRAIN at cycle 1 and rdValid at cycle 2.
- Width rules:
  - count, rdData and the subtraction are CNTW bits, unsigned.
  - count >= rdData is guaranteed while not saturated.

Optional Feature:
- Macro SEU_ERROR_ARBITER_SRCID_EN.
- Defined:
  - Adds output lastSrc, width $clog2(NREQ), reset 0.
  - lastSrc is updated with g on every grant.
  - lastSrc is captured into rdSrc, also added, width $clog2(NREQ), at the snapshot.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset then idle: hold tmrErr=0, rdReq pulse -> rdValid at cycle 2, rdData=0, rdOverflow=0, rdDropped=0.
- Fairness: tmrErr rises on all 4 sources in one cycle -> grants 0,1,2,3 on consecutive cycles; read -> rdData=4. tmrErr held high 20 cycles -> still counts 1 per source.
- Drop: source 2 pulses twice while sources 0,1,3 keep it from being granted -> rdDropped=1.
- Saturation, CNTW=4: 20 separated events -> rdData=15, rdOverflow=1. clrOnRead=1, rdAck -> next read rdData=0, rdOverflow=0.
- Clear preserves in-flight events: count=5, read with clrOnRead=1, 3 events during HOLD, then rdAck -> count=3; next read rdData=3.
- Async reset in HOLD: rst pulse mid-cycle -> rdValid, busy and the counter go to 0 without waiting for a clock edge; a subsequent rdReq works normally.

Source files
------------

// File: rtl/seu_error_arbiter.sv
// SEU error arbiter: rising-edge detects TMR voter flags, round-robin grants them into one
// saturating counter, and a read FSM snapshots (and optionally clears) it. Option: SEU_ERROR_ARBITER_SRCID_EN.
module seu_error_arbiter #(
  parameter int NREQ      = 4,
  parameter int CNTW      = 8,
  parameter int DRAIN_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          tmrErr,
  input  logic                     rdReq,
  input  logic                     clrOnRead,
  output logic                     rdValid,
  input  logic                     rdAck,
  output logic [CNTW-1:0]          rdData,
  output logic                     rdOverflow,
  output logic                     rdDropped,
  output logic                     busy
`ifdef SEU_ERROR_ARBITER_SRCID_EN
  ,
  output logic [$clog2(NREQ)-1:0]  lastSrc,
  output logic [$clog2(NREQ)-1:0]  rdSrc
`endif
);

  localparam int IDXW = $clog2(NREQ);
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_MAX - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, HOLD} state_t;

  state_t state_reg, state_next;

  logic [NREQ-1:0] tmr_err_d;
  logic [NREQ-1:0] pending_reg, pending_next;
  logic [NREQ-1:0] ev, grant_vec, drop_vec;
  logic [IDXW-1:0] ptr_reg, ptr_next;
  logic [IDXW-1:0] grant_idx;
  logic            grant_valid;
  logic            any_pending;

  logic [CNTW-1:0] count_reg, count_next, count_base;
  logic            sat_reg, sat_next, sat_base;
  logic            dropped_reg, dropped_next, dropped_base;
  logic            clear_now;

  logic [7:0]      drain_reg, drain_next;
  logic            clr_pend_reg, clr_pend_next;
  logic            valid_next;
  logic            snap;

  // Per-source edge detect and pending bookkeeping; a new event beats a same-cycle grant.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_src
    assign ev[gi]           = tmrErr[gi] & ~tmr_err_d[gi];
    assign grant_vec[gi]    = grant_valid && (grant_idx == IDXW'(gi));
    assign pending_next[gi] = ev[gi] | (pending_reg[gi] & ~grant_vec[gi]);
    assign drop_vec[gi]     = ev[gi] & pending_reg[gi] & ~grant_vec[gi];
  end

  assign any_pending = |pending_reg;

  // Round-robin search starting at ptr.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_reg) + k) % NREQ;
      if (!grant_valid && pending_reg[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IDXW'(idx);
      end
    end
  end

  assign ptr_next = (grant_idx == IDXW'(NREQ - 1)) ? '0 : grant_idx + IDXW'(1);

  // Clear-on-ack subtracts the snapshot so events counted during HOLD survive.
  assign clear_now = (state_reg == HOLD) && rdAck && clr_pend_reg;

  always_comb begin
    count_base   = count_reg;
    sat_base     = sat_reg;
    dropped_base = dropped_reg;
    if (clear_now) begin
      count_base   = sat_reg ? '0 : (count_reg - rdData);
      sat_base     = 1'b0;
      dropped_base = 1'b0;
    end
    count_next = count_base;
    sat_next   = sat_base;
    if (grant_valid) begin
      if (count_base == CNT_MAX) begin
        sat_next = 1'b1;
      end else begin
        count_next = count_base + CNTW'(1);
      end
    end
    dropped_next = dropped_base | (|drop_vec);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    drain_next    = drain_reg;
    clr_pend_next = clr_pend_reg;
    valid_next    = rdValid;
    snap          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rdReq) begin
          state_next    = DRAIN;
          clr_pend_next = clrOnRead;
          drain_next    = '0;
        end
      end
      DRAIN: begin
        if (!any_pending || (drain_reg == DRAIN_LAST)) begin
          snap       = 1'b1;
          valid_next = 1'b1;
          state_next = HOLD;
        end else begin
          drain_next = drain_reg + 8'd1;
        end
      end
      HOLD: begin
        if (rdAck) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_err_d    <= '0;
      pending_reg  <= '0;
      ptr_reg      <= '0;
      count_reg    <= '0;
      sat_reg      <= 1'b0;
      dropped_reg  <= 1'b0;
      drain_reg    <= '0;
      clr_pend_reg <= 1'b0;
      rdValid      <= 1'b0;
      rdData       <= '0;
      rdOverflow   <= 1'b0;
      rdDropped    <= 1'b0;
    end else begin
      tmr_err_d    <= tmrErr;
      pending_reg  <= pending_next;
      if (grant_valid) begin
        ptr_reg <= ptr_next;
      end
      count_reg    <= count_next;
      sat_reg      <= sat_next;
      dropped_reg  <= dropped_next;
      drain_reg    <= drain_next;
      clr_pend_reg <= clr_pend_next;
      rdValid      <= valid_next;
      if (snap) begin
        rdData     <= count_next;
        rdOverflow <= sat_next;
        rdDropped  <= dropped_next;
      end
    end
  end

`ifdef SEU_ERROR_ARBITER_SRCID_EN
  // The snapshot source matches rdData, so it includes this cycle's grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastSrc <= '0;
      rdSrc   <= '0;
    end else begin
      if (grant_valid) begin
        lastSrc <= grant_idx;
      end
      if (snap) begin
        rdSrc <= grant_valid ? grant_idx : lastSrc;
      end
    end
  end
`else
`endif

endmodule
